mult_div_ctrl: RTL and testbench

//  Multi-cycle MULT/MULTU/DIV/DIVU engine and sequencer beside the EX stage.
//  - Decodes the EX-stage funct and captures the operands.
//  - Runs a 32-step radix-2 restoring divide, and an iterative or single-cycle multiply.
//  - Returns a 64-bit {hi,lo} result with a done flag; EX holds the pipeline via stall_request = !done.

---
 rtl/mult_div_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_mult_div_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine beside the EX stage: restoring divide, iterative or single-cycle multiply.
// Build option: define MULT_DIV_ITER_MULT_EN for the 32-cycle shift-add multiplier instead of the '*' operator.
`timescale 1ns/1ps

module mult_div_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      stall_hold,
  input  logic [5:0]                funct,
  input  logic [DATA_WIDTH-1:0]     operand_1,
  input  logic [DATA_WIDTH-1:0]     operand_2,
  output logic                      mult_div_done,
  output logic [2*DATA_WIDTH-1:0]   mult_div_result
);

  localparam int W = DATA_WIDTH;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_done;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [W-1:0]         r_rem;
  logic [W-1:0]         r_q;
  logic [W-1:0]         r_dvsr;
  logic                 r_sign_q;
  logic                 r_sign_r;
  logic [2*W-1:0]       r_result;

  logic                 w_is_mult;
  logic                 w_is_div;
  logic                 w_is_signed;
  logic                 w_start;
  logic                 w_s1;
  logic                 w_s2;
  logic                 w_sq;
  logic [W-1:0]         w_neg1;
  logic [W-1:0]         w_neg2;
  logic [W-1:0]         w_mag1;
  logic [W-1:0]         w_mag2;
  logic                 w_res_we;
  logic [2*W-1:0]       w_res_d;

  // ---------------------------------------------------------------------------
  // Decode and operand magnitudes (0x80000000 maps to 2^31 through the W-bit negate)
  // ---------------------------------------------------------------------------
  assign w_is_mult   = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
  assign w_is_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign w_is_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign w_start     = (r_state == S_IDLE) && (w_is_mult || w_is_div) && !flush;

  assign w_s1   = w_is_signed & operand_1[W-1];
  assign w_s2   = w_is_signed & operand_2[W-1];
  assign w_sq   = w_s1 ^ w_s2;
  assign w_neg1 = -operand_1;
  assign w_neg2 = -operand_2;
  assign w_mag1 = w_s1 ? w_neg1 : operand_1;
  assign w_mag2 = w_s2 ? w_neg2 : operand_2;

  // ---------------------------------------------------------------------------
  // Restoring divide step: compare in W+1 bits, subtract only when it fits
  // ---------------------------------------------------------------------------
  logic [W:0]   w_rem_shift;
  logic [W-1:0] w_diff;
  logic         w_ge;
  logic [W-1:0] w_rem_next;
  logic [W-1:0] w_q_next;
  logic [W-1:0] w_quot_final;
  logic [W-1:0] w_rem_final;
  logic         w_last;

  assign w_rem_shift  = {r_rem, r_q[W-1]};
  assign w_ge         = (w_rem_shift >= {1'b0, r_dvsr});
  assign w_diff       = w_rem_shift[W-1:0] - r_dvsr;
  assign w_rem_next   = w_ge ? w_diff : w_rem_shift[W-1:0];
  assign w_q_next     = {r_q[W-2:0], w_ge};
  assign w_quot_final = r_sign_q ? -w_q_next   : w_q_next;
  assign w_rem_final  = r_sign_r ? -w_rem_next : w_rem_next;
  assign w_last       = (r_cnt == CNT_WIDTH'(W - 1));

`ifdef MULT_DIV_ITER_MULT_EN
  // Shift-add multiply: r_q holds the multiplier, consumed LSB first.
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] w_acc_next;
  logic [2*W-1:0] w_prod_final;

  assign w_acc_next   = r_acc + (r_q[0] ? r_mcand : '0);
  assign w_prod_final = r_sign_q ? -w_acc_next : w_acc_next;
`else
  logic [2*W-1:0] w_prod_mag;
  logic [2*W-1:0] w_prod_final;

  assign w_prod_mag   = {{W{1'b0}}, w_mag1} * {{W{1'b0}}, w_mag2};
  assign w_prod_final = w_sq ? -w_prod_mag : w_prod_mag;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    w_state_next = r_state;
    w_res_we     = 1'b0;
    w_res_d      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_is_div) begin
            if (operand_2 == '0) begin
              w_state_next = S_DONE;
              w_res_we     = 1'b1;
              w_res_d      = {operand_1, {W{1'b1}}};
            end else begin
              w_state_next = S_DIV;
            end
          end else begin
`ifdef MULT_DIV_ITER_MULT_EN
            w_state_next = S_MUL;
`else
            w_state_next = S_DONE;
            w_res_we     = 1'b1;
            w_res_d      = w_prod_final;
`endif
          end
        end
      end
      S_DIV: begin
        if (w_last) begin
          w_state_next = S_DONE;
          w_res_we     = 1'b1;
          w_res_d      = {w_rem_final, w_quot_final};
        end
      end
      S_MUL: begin
`ifdef MULT_DIV_ITER_MULT_EN
        if (w_last) begin
          w_state_next = S_DONE;
          w_res_we     = 1'b1;
          w_res_d      = w_prod_final;
        end
`else
        w_state_next = S_IDLE;
`endif
      end
      S_DONE: begin
        if (!stall_hold) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // Flush wins over everything, including a completing step.
    if (flush) begin
      w_state_next = S_IDLE;
      w_res_we     = 1'b0;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (w_state_next == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
    end else if (w_res_we) begin
      r_result <= w_res_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_dvsr   <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
`ifdef MULT_DIV_ITER_MULT_EN
      r_acc    <= '0;
      r_mcand  <= '0;
`endif
    end else if (w_start) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_q      <= w_is_div ? w_mag1 : w_mag2;
      r_dvsr   <= w_mag2;
      r_sign_q <= w_sq;
      r_sign_r <= w_s1;
`ifdef MULT_DIV_ITER_MULT_EN
      r_acc    <= '0;
      r_mcand  <= {{W{1'b0}}, w_mag1};
`endif
    end else if (r_state == S_DIV) begin
      r_rem <= w_rem_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt + 1'b1;
    end
`ifdef MULT_DIV_ITER_MULT_EN
    else if (r_state == S_MUL) begin
      r_acc   <= w_acc_next;
      r_mcand <= r_mcand << 1;
      r_q     <= r_q >> 1;
      r_cnt   <= r_cnt + 1'b1;
    end
`endif
  end

  assign mult_div_done   = r_done;
  assign mult_div_result = r_result;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: arithmetic reference model, directed corner cases plus random ops.
`timescale 1ns/1ps

module tb_mult_div_ctrl;

  localparam logic [5:0] F_NOP   = 6'h00;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

`ifdef MULT_DIV_ITER_MULT_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        stall_hold;
  logic [5:0]  funct;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        done;
  logic [63:0] result;

  always #5 clk = ~clk;

  mult_div_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .stall_hold      (stall_hold),
    .funct           (funct),
    .operand_1       (op1),
    .operand_2       (op2),
    .mult_div_done   (done),
    .mult_div_result (result)
  );

  typedef struct {
    logic [63:0] res;
    int          start;
    int          lat;
    int          id;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_ops = 0;
  logic [63:0] cur_exp = '0;
  logic [63:0] last_exp = '0;
  logic        prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural operands.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      F_MULTU: p = {32'b0, a} * {32'b0, b};
      F_MULT:  p = 64'(sa * sb);
      F_DIVU:  p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          p  = {sr[31:0], sq[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  function automatic int latency(input logic [5:0] f, input logic [31:0] b);
    if (f == F_MULT || f == F_MULTU) return MUL_LAT;
    return (b == 0) ? 1 : 33;
  endfunction

  // Monitor: every rising done consumes one scoreboard entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done && !prev_done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        e = sb_q.pop_front();
        check($sformatf("result_op%0d", e.id), result, e.res);
        check($sformatf("latency_op%0d", e.id), 64'(cyc - e.start), 64'(e.lat));
      end
    end
    prev_done <= done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op in the current cycle (cycle 0); optionally score it.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit track);
    exp_t e;
    funct = f;
    op1   = a;
    op2   = b;
    if (track) begin
      e.res   = model(f, a, b);
      e.start = cyc;
      e.lat   = latency(f, b);
      e.id    = n_ops;
      n_ops++;
      sb_q.push_back(e);
      cur_exp = e.res;
    end
  endtask

  task automatic finish_op(input int stall);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in 40 cycles expected done");
    end
    if (got && stall > 0) begin
      stall_hold = 1'b1;
      repeat (stall) begin
        @(negedge clk);
        check("stall_done", 64'(done), 64'd1);
        check("stall_result", result, cur_exp);
      end
      stall_hold = 1'b0;
    end
    step();
    funct = F_NOP;
    if (got) last_exp = cur_exp;
    @(negedge clk);
    check("done_drop", 64'(done), 64'd0);
    check("hold_idle", result, last_exp);
  endtask

  task automatic run(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int stall);
    step();
    issue(f, a, b, 1'b1);
    finish_op(stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0]  f;
    logic [31:0] a, b;
    int          stall;

    rst        = 1'b1;
    flush      = 1'b0;
    stall_hold = 1'b0;
    funct      = F_NOP;
    op1        = '0;
    op2        = '0;
    repeat (2) @(negedge clk);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    rst = 1'b0;

    // Directed corner cases.
    run(F_DIVU,  32'd100,       32'd7,         0);
    run(F_DIV,   32'hFFFF_FFF9, 32'd2,         0);
    run(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(F_MULT,  32'hFFFF_FFFF, 32'd2,         0);
    run(F_MULTU, 32'hFFFF_FFFF, 32'd2,         0);
    run(F_DIVU,  32'd5,         32'd0,         0);
    run(F_DIV,   32'h8000_0000, 32'd0,         0);
    run(F_MULT,  32'h8000_0000, 32'h8000_0000, 0);
    run(F_DIV,   32'd7,         32'hFFFF_FFFE, 0);
    run(F_DIVU,  32'd100,       32'd7,         3);

    // Flush in DIV cycle 10, then an immediate DIVU 9/3.
    step();
    issue(F_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    issue(F_DIVU, 32'd9, 32'd3, 1'b1);
    @(negedge clk);
    check("flush_done", 64'(done), 64'd0);
    check("flush_result", result, last_exp);
    finish_op(0);

    // Random operations.
    for (int i = 0; i < 24; i++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run(f, a, b, stall);
    end

    // Async reset pulse in the middle of a divide.
    step();
    issue(F_DIV, 32'd1000, 32'd7, 1'b0);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_result", result, 64'd0);
    #2;
    rst      = 1'b0;
    funct    = F_NOP;
    last_exp = '0;
    run(F_DIVU, 32'd9, 32'd3, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
